leds_responder: RTL
===================

Name: leds_responder

Overview:
- Memory-mapped LED peripheral that acts as the responder on the core's data bus. It receives the request that the address decoder qualifies for the LED window.
- Holds the LED value, blink control and blink period registers, and drives the board LEDs with an optional hardware blink.
- Reads return registered data after a fixed one-cycle latency. The returned data feeds the core's read-data mux on the LEDs select.

Parameters:
- LED_WIDTH, 16, number of LED outputs. Legal range 1..32.
- BASE_ADDR, 32'h8000_0800, base of the 16-byte register window. Must be 16-byte aligned.
- PERIOD_RST, 32'd25_000_000, reset value of the PERIOD register, in clock cycles.

Ports:
- clk_i, input, 1, system clock. All logic is on the rising edge.
- rst_i, input, 1, reset, synchronous, active-high.
- req_i, input, 1, access request from the address decoder. Valid for one cycle per access.
- we_i, input, 1, 1 = write, 0 = read. Sampled with req_i.
- be_i, input, 4, byte enables for writes. Ignored on reads.
- addr_i, input, 32, byte address.
- wdata_i, input, 32, write data.
- rdata_o, output, 32, read data. Registered.
- rvalid_o, output, 1, one-cycle pulse marking rdata_o as valid.
- led_o, output, LED_WIDTH, LED drive. Registered.

Behaviour:
- Window hit: addr_i[31:4] == BASE_ADDR[31:4]. Register select is addr_i[3:2]; addr_i[1:0] is ignored.
- Register map:
  - 0x0 LED_VAL: RW, bits [LED_WIDTH-1:0]. Upper bits read as 0.
  - 0x4 CTRL: RW, bit0 = blink_en. Bits [31:1] read as 0.
  - 0x8 PERIOD: RW, 32 bits.
  - 0xC STATUS: RO. bit0 = phase, bits [15:1] = 0, bits [31:16] = LED_WIDTH. Writes are ignored.
- Write (req_i & we_i & hit): each byte lane k with be_i[k]=1 updates that byte of the selected register at the clock edge. The new value is visible to a read on the next cycle. No rvalid_o pulse for writes.
- Read (req_i & ~we_i):
  - rvalid_o = 1 exactly one cycle later.
  - rdata_o = the selected register, or 0 on a window miss. The value is sampled at the request edge.
  - rdata_o holds its value until the next read; rvalid_o is 0 otherwise.
- Write on a window miss: ignored, no state change.
- Back-to-back reads on consecutive cycles: rvalid_o stays high for consecutive cycles, and each cycle carries the data for the matching request.
- Blink engine: a 32-bit counter cnt and a 1-bit phase.
  - blink_en=0: cnt=0, phase=1, led_o = LED_VAL.
  - blink_en=1: each cycle, if cnt == PERIOD then cnt <= 0 and phase <= ~phase; otherwise cnt <= cnt+1. led_o = phase ? LED_VAL : 0.
  - PERIOD=0 makes phase toggle every cycle.
  - Effective half-period is PERIOD+1 cycles.
- led_o is registered: it reflects register and phase state with one cycle of latency.
- Any write that touches PERIOD or CTRL: cnt <= 0 and phase <= 1 on the same edge. This restart applies even if blink_en is unchanged, and has priority over the counter-wrap toggle.
- A write to LED_VAL while blinking does not restart the counter. The new value appears on led_o while phase=1.
- A PERIOD write below the current cnt takes effect cleanly, because the same write also zeroes cnt.
- Reset values: LED_VAL=0, CTRL=0, PERIOD=PERIOD_RST, cnt=0, phase=1, rdata_o=0, rvalid_o=0, led_o=0.
- Reset mid-operation: rst_i has priority over req_i. A read accepted in the cycle before reset asserts produces no rvalid_o. All state returns to reset values on the reset edge.

Test Plan:
- Reset, then read 0xC: rvalid_o pulses 1 cycle after req. rdata_o = 0x0010_0001 (LED_WIDTH=16, phase=1). led_o = 0.
- Write 0x8000_0800 wdata=0xA5A5_1234 be=4'b0001, then read 0x0: rdata_o = 0x0000_0034. led_o = 0x0034 one cycle after the write.
- Write PERIOD=3, then CTRL=1 with LED_VAL=0xFFFF: led_o alternates 0xFFFF / 0x0000 every 4 cycles. STATUS bit0 tracks the phase.
- Blinking with LED_VAL=0x00FF, rewrite PERIOD=3 mid-count: cnt restarts, phase=1, led_o=0x00FF for the next 4 cycles.
- Read 0x8000_0900 (window miss) and write to it: rdata_o=0 with rvalid_o=1; register contents unchanged.
- Issue a read, then assert rst_i on the next edge: rvalid_o stays 0, all registers return to reset values. Reads on 3 consecutive cycles to 0x0/0x4/0x8 produce 3 consecutive rvalid_o pulses with the matching data.

Source files
------------

// File: rtl/leds_responder.sv
// ---------------------------------------------------------------------------
// leds_responder
//
// Memory-mapped LED peripheral. It sits behind the core's address decoder as
// the responder for a 16-byte register window. It holds the LED value, blink
// control and blink period registers, and drives the board LEDs with an
// optional hardware blink.
//
// Register map (byte offsets from BASE_ADDR, addr_i[1:0] ignored):
//   0x0 LED_VAL  RW  [LED_WIDTH-1:0] LED pattern, upper bits read as 0
//   0x4 CTRL     RW  bit0 = blink_en
//   0x8 PERIOD   RW  blink half-period minus one, in clock cycles
//   0xC STATUS   RO  bit0 = phase, [31:16] = LED_WIDTH
//
// Ports:
//   clk_i     system clock, rising edge
//   rst_i     synchronous active-high reset
//   req_i     one-cycle access request from the address decoder
//   we_i      1 = write, 0 = read (sampled with req_i)
//   be_i      write byte enables
//   addr_i    byte address
//   wdata_i   write data
//   rdata_o   registered read data, held until the next read
//   rvalid_o  one-cycle pulse, one cycle after a read request
//   led_o     registered LED drive
// ---------------------------------------------------------------------------
module leds_responder #(
    parameter int          LED_WIDTH  = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0800,
    parameter logic [31:0] PERIOD_RST = 32'd25_000_000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          wdata_i,
    output logic [31:0]          rdata_o,
    output logic                 rvalid_o,
    output logic [LED_WIDTH-1:0] led_o
);

    typedef enum logic [1:0] {
        REG_LED    = 2'd0,
        REG_CTRL   = 2'd1,
        REG_PERIOD = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    localparam logic [15:0] WIDTH_FIELD = 16'(LED_WIDTH);

    logic [LED_WIDTH-1:0] led_val;
    logic                 blink_en;
    logic [31:0]          period;
    logic [31:0]          cnt;
    logic                 phase;
    logic [31:0]          rdata_q;
    logic                 rvalid_q;
    logic [LED_WIDTH-1:0] led_q;

    logic                 hit;
    reg_sel_e             sel;
    logic                 wr_hit;
    logic                 rd_req;
    logic                 restart;
    logic [31:0]          led_val_ext;
    logic [31:0]          led_merged;
    logic [31:0]          period_merged;
    logic [31:0]          rd_mux;

    // Byte-lane merge of write data into the current register contents.
    function automatic logic [31:0] merge_be(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = wd[8*k +: 8];
            end
        end
        return res;
    endfunction

    assign hit     = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign sel     = reg_sel_e'(addr_i[3:2]);
    assign wr_hit  = req_i & we_i & hit;
    assign rd_req  = req_i & ~we_i;
    // Touching CTRL or PERIOD always restarts the blink sequence from a
    // clean "LEDs on" phase, even when the written value is unchanged.
    assign restart = wr_hit & ((sel == REG_CTRL) | (sel == REG_PERIOD));

    // NOTE: every variable assigned in always_comb gets a default first so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        led_val_ext = '0;
        led_val_ext[LED_WIDTH-1:0] = led_val;
        led_merged    = merge_be(led_val_ext, wdata_i, be_i);
        period_merged = merge_be(period, wdata_i, be_i);

        rd_mux = '0;
        if (hit) begin
            case (sel)
                REG_LED:    rd_mux = led_val_ext;
                REG_CTRL:   rd_mux[0] = blink_en;
                REG_PERIOD: rd_mux = period;
                REG_STATUS: rd_mux = {WIDTH_FIELD, 15'd0, phase};
                default:    rd_mux = '0;
            endcase
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others (reads see the
    // value from before a same-edge write).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            led_val  <= '0;
            blink_en <= 1'b0;
            period   <= PERIOD_RST;
            cnt      <= '0;
            phase    <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            led_q    <= '0;
        end else begin
            if (wr_hit) begin
                case (sel)
                    REG_LED:    led_val  <= led_merged[LED_WIDTH-1:0];
                    REG_CTRL:   blink_en <= be_i[0] ? wdata_i[0] : blink_en;
                    REG_PERIOD: period   <= period_merged;
                    default:    ;
                endcase
            end

            // Restart wins over the wrap toggle; a disabled engine parks
            // in the "on" phase so led_o simply follows LED_VAL.
            if (restart || !blink_en) begin
                cnt   <= '0;
                phase <= 1'b1;
            end else if (cnt == period) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 32'd1;
            end

            rvalid_q <= rd_req;
            if (rd_req) begin
                rdata_q <= rd_mux;
            end

            led_q <= (blink_en && !phase) ? '0 : led_val;
        end
    end

    // A read accepted just before reset asserts must not report data: the
    // pending pulse is suppressed while reset is active.
    assign rvalid_o = rvalid_q & ~rst_i;
    assign rdata_o  = rdata_q;
    assign led_o    = led_q;

endmodule
